// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci stream checker.
package fib_pkg;

  localparam int FIB_WIDTH = 8;

  typedef logic [FIB_WIDTH-1:0] fib_word_t;

  typedef enum logic [1:0] {
    LOCKED = 2'd0,
    HUNT   = 2'd1,
    SEED   = 2'd2,
    FAIL   = 2'd3
  } fib_chk_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fib_stream_checker.sv
// Shadows the Fibonacci generator state, predicts each sample and re-locks
// after a mismatch by hunting for two consecutive advance samples.
module fib_stream_checker
  import fib_pkg::*;
#(
  parameter int WIDTH  = FIB_WIDTH,
  parameter int CNT_W  = 16,
  parameter bit RESYNC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_hold,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             fail,
  output logic             err,
  output logic             match,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  fib_chk_state_e   state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_q, err_d;
  logic             match_q, match_d;
  logic [WIDTH-1:0] pred;
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] sum_vw;

  assign pred   = in_hold ? a_q : b_q;
  assign sum_ab = a_q + b_q;
  assign sum_vw = v_q + in_data;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    v_d     = v_q;
    exp_d   = exp_q;
    err_d   = 1'b0;
    match_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        LOCKED: begin
          exp_d = pred;
          // The model advances from its own state, never from in_data.
          if (!in_hold) begin
            a_d = b_q;
            b_d = sum_ab;
          end
          if (in_data == pred) begin
            match_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            state_d = RESYNC ? HUNT : FAIL;
          end
        end
        HUNT: begin
          exp_d = in_data;
          if (!in_hold) begin
            v_d     = in_data;
            state_d = SEED;
          end
        end
        SEED: begin
          if (in_hold) begin
            exp_d = v_q;
            if (in_data == v_q) begin
              match_d = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end else begin
            exp_d   = in_data;
            a_d     = in_data;
            b_d     = sum_vw;
            match_d = 1'b1;
            state_d = LOCKED;
          end
        end
        default: begin
          exp_d = in_data;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOCKED;
      a_q     <= '0;
      b_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
      v_q     <= '0;
      exp_q   <= '0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v_q     <= v_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      match_q <= match_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_d),
    .count (match_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_d),
    .count (err_cnt)
  );

  assign locked   = (state_q == LOCKED);
  assign fail     = (state_q == FAIL);
  assign err      = err_q;
  assign match    = match_q;
  assign expected = exp_q;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Directed bench: three checker instances (resync, sticky-fail, 4-bit counters)
// share one stimulus stream.
module tb_fib_stream_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_hold = 1'b0;
  logic [7:0] in_data = '0;

  logic        locked, fail, err, match;
  logic [7:0]  expected;
  logic [15:0] match_cnt, err_cnt;

  logic        nr_locked, nr_fail, nr_err, nr_match;
  logic [7:0]  nr_expected;
  logic [15:0] nr_match_cnt, nr_err_cnt;

  logic        s_locked, s_fail, s_err, s_match;
  logic [7:0]  s_expected;
  logic [3:0]  s_match_cnt, s_err_cnt;

  int tests = 0;
  int fails = 0;

  // Generator output from reset: 1,1,2,...,233 then modulo-256 wrap values.
  logic [7:0] fib_tab [20] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                               8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98,
                               8'd219, 8'd61, 8'd24, 8'd85, 8'd109};

  always #5 clk = ~clk;

  fib_stream_checker #(.WIDTH(8), .CNT_W(16), .RESYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hold(in_hold), .in_data(in_data),
    .locked(locked), .fail(fail), .err(err), .match(match), .expected(expected),
    .match_cnt(match_cnt), .err_cnt(err_cnt)
  );

  fib_stream_checker #(.WIDTH(8), .CNT_W(16), .RESYNC(1'b0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hold(in_hold), .in_data(in_data),
    .locked(nr_locked), .fail(nr_fail), .err(nr_err), .match(nr_match),
    .expected(nr_expected), .match_cnt(nr_match_cnt), .err_cnt(nr_err_cnt)
  );

  fib_stream_checker #(.WIDTH(8), .CNT_W(4), .RESYNC(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_hold(in_hold), .in_data(in_data),
    .locked(s_locked), .fail(s_fail), .err(s_err), .match(s_match),
    .expected(s_expected), .match_cnt(s_match_cnt), .err_cnt(s_err_cnt)
  );

  task automatic send(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    in_valid = v;
    in_hold  = h;
    in_data  = d;
    @(posedge clk);
    #1;
    $display("[TB] t=%0t valid=%0b hold=%0b data=%0d -> locked=%0b fail=%0b match=%0b err=%0b exp=%0d mcnt=%0d ecnt=%0d",
             $time, v, h, d, locked, fail, match, err, expected, match_cnt, err_cnt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL reset_locked got %0b want 1", locked); end
    tests++; if (fail !== 1'b0) begin fails++; $display("FAIL reset_fail got %0b want 0", fail); end
    tests++; if ({err, match} !== 2'b00) begin fails++; $display("FAIL reset_pulses got err=%0b match=%0b want 0,0", err, match); end
    tests++; if (expected !== 8'd0) begin fails++; $display("FAIL reset_expected got %0d want 0", expected); end
    tests++; if ({match_cnt, err_cnt} !== 32'd0) begin fails++; $display("FAIL reset_counters got %0d,%0d want 0,0", match_cnt, err_cnt); end
  endtask

  task automatic test_sequence();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      send(1'b1, 1'b0, fib_tab[i]);
      tests++; if ({locked, match, err} !== 3'b110) begin fails++; $display("FAIL seq[%0d] got locked=%0b match=%0b err=%0b want 1,1,0", i, locked, match, err); end
      tests++; if (expected !== fib_tab[i]) begin fails++; $display("FAIL seq_exp[%0d] got %0d want %0d", i, expected, fib_tab[i]); end
    end
    tests++; if (match_cnt !== 16'd13) begin fails++; $display("FAIL seq_match_cnt got %0d want 13", match_cnt); end
    tests++; if (err_cnt !== 16'd0) begin fails++; $display("FAIL seq_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_wrap();
    send(1'b1, 1'b0, 8'd121);
    tests++; if ({match, err, expected} !== {2'b10, 8'd121}) begin fails++; $display("FAIL wrap_121 got match=%0b err=%0b exp=%0d want 1,0,121", match, err, expected); end
    send(1'b1, 1'b0, 8'd98);
    tests++; if ({match, err, expected} !== {2'b10, 8'd98}) begin fails++; $display("FAIL wrap_98 got match=%0b err=%0b exp=%0d want 1,0,98", match, err, expected); end
    tests++; if (match_cnt !== 16'd15) begin fails++; $display("FAIL wrap_match_cnt got %0d want 15", match_cnt); end
  endtask

  task automatic test_hold_start();
    do_reset();
    send(1'b1, 1'b1, 8'd0);
    tests++; if ({match, expected} !== {1'b1, 8'd0}) begin fails++; $display("FAIL hold0 got match=%0b exp=%0d want 1,0", match, expected); end
    send(1'b1, 1'b0, 8'd1);
    tests++; if (match !== 1'b1) begin fails++; $display("FAIL hold_adv1 got %0b want 1", match); end
    // Shadow is now (1,1): a hold then an advance both predict 1, then 2.
    send(1'b1, 1'b1, 8'd1);
    tests++; if ({match, expected} !== {1'b1, 8'd1}) begin fails++; $display("FAIL hold_a1 got match=%0b exp=%0d want 1,1", match, expected); end
    send(1'b1, 1'b0, 8'd1);
    tests++; if ({match, expected} !== {1'b1, 8'd1}) begin fails++; $display("FAIL hold_b1 got match=%0b exp=%0d want 1,1", match, expected); end
    send(1'b1, 1'b0, 8'd2);
    tests++; if ({match, expected} !== {1'b1, 8'd2}) begin fails++; $display("FAIL hold_b2 got match=%0b exp=%0d want 1,2", match, expected); end
  endtask

  task automatic test_resync();
    do_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, fib_tab[i]);
    send(1'b1, 1'b0, 8'd7);
    tests++; if ({err, match, locked} !== 3'b100) begin fails++; $display("FAIL rs_err got err=%0b match=%0b locked=%0b want 1,0,0", err, match, locked); end
    tests++; if ({expected, err_cnt} !== {8'd8, 16'd1}) begin fails++; $display("FAIL rs_exp_cnt got exp=%0d ecnt=%0d want 8,1", expected, err_cnt); end
    tests++; if ({nr_fail, nr_locked, nr_err} !== 3'b101) begin fails++; $display("FAIL nr_enter got fail=%0b locked=%0b err=%0b want 1,0,1", nr_fail, nr_locked, nr_err); end
    send(1'b1, 1'b1, 8'd99);
    tests++; if ({err, match, err_cnt} !== {2'b00, 16'd1}) begin fails++; $display("FAIL rs_hunt_hold got err=%0b match=%0b ecnt=%0d want 0,0,1", err, match, err_cnt); end
    send(1'b1, 1'b0, 8'd13);
    tests++; if ({err, match, locked, expected} !== {3'b000, 8'd13}) begin fails++; $display("FAIL rs_seed13 got err=%0b match=%0b locked=%0b exp=%0d want 0,0,0,13", err, match, locked, expected); end
    send(1'b1, 1'b1, 8'd13);
    tests++; if ({match, locked, match_cnt} !== {2'b10, 16'd6}) begin fails++; $display("FAIL rs_seed_hold got match=%0b locked=%0b mcnt=%0d want 1,0,6", match, locked, match_cnt); end
    send(1'b1, 1'b0, 8'd21);
    tests++; if ({match, locked, expected} !== {2'b11, 8'd21}) begin fails++; $display("FAIL rs_lock21 got match=%0b locked=%0b exp=%0d want 1,1,21", match, locked, expected); end
    send(1'b1, 1'b0, 8'd34);
    tests++; if ({match, err, expected} !== {2'b10, 8'd34}) begin fails++; $display("FAIL rs_34 got match=%0b err=%0b exp=%0d want 1,0,34", match, err, expected); end
    tests++; if ({match_cnt, err_cnt} !== {16'd8, 16'd1}) begin fails++; $display("FAIL rs_counts got %0d,%0d want 8,1", match_cnt, err_cnt); end
    tests++; if ({nr_fail, nr_match, nr_err} !== 3'b100) begin fails++; $display("FAIL nr_sticky got fail=%0b match=%0b err=%0b want 1,0,0", nr_fail, nr_match, nr_err); end
    tests++; if ({nr_match_cnt, nr_err_cnt} !== {16'd5, 16'd1}) begin fails++; $display("FAIL nr_counts got %0d,%0d want 5,1", nr_match_cnt, nr_err_cnt); end
    do_reset();
    tests++; if ({nr_fail, nr_locked} !== 2'b01) begin fails++; $display("FAIL nr_reset got fail=%0b locked=%0b want 0,1", nr_fail, nr_locked); end
    tests++; if ({nr_match_cnt, nr_err_cnt} !== 32'd0) begin fails++; $display("FAIL nr_reset_cnt got %0d,%0d want 0,0", nr_match_cnt, nr_err_cnt); end
    send(1'b1, 1'b0, 8'd1);
    tests++; if ({nr_match, nr_expected} !== {1'b1, 8'd1}) begin fails++; $display("FAIL nr_relock got match=%0b exp=%0d want 1,1", nr_match, nr_expected); end
  endtask

  task automatic test_saturation();
    logic [3:0] want;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0, fib_tab[i]);
      want = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
      tests++; if ({s_match, s_err, s_match_cnt} !== {2'b10, want}) begin fails++; $display("FAIL sat[%0d] got match=%0b err=%0b cnt=%0d want 1,0,%0d", i, s_match, s_err, s_match_cnt, want); end
      if (i % 4 == 3) begin
        send(1'b0, 1'b0, 8'hA5);
        tests++; if ({s_match, s_err, s_locked, s_match_cnt, s_expected} !== {3'b001, want, fib_tab[i]}) begin
          fails++; $display("FAIL idle[%0d] got match=%0b err=%0b locked=%0b cnt=%0d exp=%0d want 0,0,1,%0d,%0d",
                            i, s_match, s_err, s_locked, s_match_cnt, s_expected, want, fib_tab[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_wrap();
    test_hold_start();
    test_resync();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
